// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and helpers for the UART receive path.
//   rx_state_t : receiver FSM state encoding
//   calc_div   : system clocks per oversample tick, truncated, never below 1
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic int calc_div(input int sys_clk, input int baud, input int os);
        int d;
        d = sys_clk / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen -- oversample tick generator (single-cycle enable pulse, no derived clock).
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   clear  in  restart the divider at 0 (phase-aligns ticks to a start edge)
//   tick   out high for one clk when the divider reaches DIV-1
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int SYS_CLK    = 12000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int DIV = calc_div(SYS_CLK, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- oversampling asynchronous serial receiver (1 start, DATA_BITS data LSB-first,
// 1 stop, no parity) with a ready/ack holding register.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   enable      in   1 = receive; 0 = FSM held in IDLE, tick divider cleared
//   rx_wire     in   serial line, idle high, asynchronous to clk
//   rx_data     out  last good word
//   data_ready  out  rx_data holds an unread word
//   data_ack    in   consumer read strobe; clears data_ready and overrun
//   frame_err   out  one-clk pulse when the stop bit is sampled low
//   overrun     out  sticky: a good frame arrived while data_ready was still set
//
// state    | meaning
// RX_IDLE  | waiting; arms after line seen high, falling edge starts a frame
// RX_START | counting to mid start bit, rejects glitches
// RX_DATA  | sampling DATA_BITS bits, one per OVERSAMPLE ticks
// RX_STOP  | sampling stop bit, qualifying the frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BAUD       = 9600,
    parameter int SYS_CLK    = 12000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 rx_wire,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    input  logic                 data_ack,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic rx_meta;
    logic rx_s;
    logic tick;
    logic tick_clear;

    rx_state_t            state,     state_nxt;
    logic [SW-1:0]        s_cnt,     s_cnt_nxt;
    logic [BW-1:0]        b_cnt,     b_cnt_nxt;
    logic                 armed,     armed_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic                 good_frame;
    logic                 bad_frame;

    // Two-flop synchronizer; idle-high reset value so reset does not look like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_wire;
            rx_s    <= rx_meta;
        end
    end

    uart_tick_gen #(
        .SYS_CLK    (SYS_CLK),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            s_cnt     <= '0;
            b_cnt     <= '0;
            armed     <= 1'b0;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            s_cnt     <= s_cnt_nxt;
            b_cnt     <= b_cnt_nxt;
            armed     <= armed_nxt;
            shift_reg <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        s_cnt_nxt  = s_cnt;
        b_cnt_nxt  = b_cnt;
        armed_nxt  = armed;
        shift_nxt  = shift_reg;
        tick_clear = 1'b0;
        good_frame = 1'b0;
        bad_frame  = 1'b0;

        if (!enable) begin
            state_nxt  = RX_IDLE;
            s_cnt_nxt  = '0;
            b_cnt_nxt  = '0;
            armed_nxt  = 1'b0;
            tick_clear = 1'b1;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (!armed) begin
                        if (rx_s) armed_nxt = 1'b1;
                    end else if (!rx_s) begin
                        // Restart the divider so sampling is phased to this edge.
                        state_nxt  = RX_START;
                        s_cnt_nxt  = '0;
                        tick_clear = 1'b1;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (s_cnt == S_MID) begin
                            if (!rx_s) begin
                                state_nxt = RX_DATA;
                                s_cnt_nxt = '0;
                                b_cnt_nxt = '0;
                            end else begin
                                // Line back high by mid-bit: a glitch. Stay armed.
                                state_nxt = RX_IDLE;
                                s_cnt_nxt = '0;
                            end
                        end else begin
                            s_cnt_nxt = s_cnt + SW'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (s_cnt == S_LAST) begin
                            shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
                            s_cnt_nxt = '0;
                            if (b_cnt == B_LAST) begin
                                state_nxt = RX_STOP;
                                b_cnt_nxt = '0;
                            end else begin
                                b_cnt_nxt = b_cnt + BW'(1);
                            end
                        end else begin
                            s_cnt_nxt = s_cnt + SW'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (s_cnt == S_LAST) begin
                            state_nxt = RX_IDLE;
                            s_cnt_nxt = '0;
                            if (rx_s) begin
                                good_frame = 1'b1;
                            end else begin
                                // Disarm so a held-low break line cannot retrigger.
                                bad_frame = 1'b1;
                                armed_nxt = 1'b0;
                            end
                        end else begin
                            s_cnt_nxt = s_cnt + SW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = RX_IDLE;
                    s_cnt_nxt = '0;
                    b_cnt_nxt = '0;
                    armed_nxt = 1'b0;
                end
            endcase
        end
    end

    // Holding register: an ack in the completing cycle frees the slot for the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= bad_frame;
            if (good_frame) begin
                if (!data_ready || data_ack) begin
                    rx_data    <= shift_reg;
                    data_ready <= 1'b1;
                    if (data_ack) overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_ack && data_ready) begin
                data_ready <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule
